// File: rtl/osd_io_master.sv
// OSD io bus initiator: serializes a command byte plus req_len data words into
// io_osd / io_strobe / io_din select-strobe cycles for the OSD overlay.
module osd_io_master #(
    parameter int STROBE_HI = 2,
    parameter int STROBE_LO = 2,
    parameter int GAP       = 4,
    parameter int LEN_W     = 13
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_cmd,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [15:0]      wr_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             io_osd,
    output logic             io_strobe,
    output logic [15:0]      io_din
);

    localparam int CNT_MAX_HL = (STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO;
    localparam int CNT_MAX    = (CNT_MAX_HL > GAP) ? CNT_MAX_HL : GAP;
    localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(STROBE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(STROBE_LO - 1);
    localparam logic [CNT_W-1:0] LO_EARLY = CNT_W'((STROBE_LO >= 2) ? STROBE_LO - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam bit               FETCH_FROM_HI = (STROBE_LO == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_HI,
        S_LO,
        S_FETCH,
        S_SETUP,
        S_GAP
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   rem_reg;
    logic               abort_seen_reg;

    logic abort_any;
    logic more_words;

    assign abort_any  = abort | abort_seen_reg;
    assign more_words = (rem_reg != '0) && !abort_any;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            rem_reg        <= '0;
            abort_seen_reg <= 1'b0;
            req_ready      <= 1'b1;
            wr_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            io_osd         <= 1'b0;
            io_strobe      <= 1'b0;
            io_din         <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state_reg != S_IDLE && state_reg != S_GAP) begin
                abort_seen_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        state_reg      <= S_SEL;
                        rem_reg        <= req_len;
                        abort_seen_reg <= 1'b0;
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        io_osd         <= 1'b1;
                        io_din         <= {8'h00, req_cmd};
                    end
                end

                S_SEL: begin
                    state_reg <= S_HI;
                    io_strobe <= 1'b1;
                    cnt_reg   <= '0;
                end

                S_HI: begin
                    if (cnt_reg == HI_LAST) begin
                        io_strobe <= 1'b0;
                        cnt_reg   <= '0;
                        if (FETCH_FROM_HI && more_words) begin
                            state_reg <= S_FETCH;
                            wr_ready  <= 1'b1;
                        end else begin
                            state_reg <= S_LO;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                // When another word follows, FETCH stands in for the last low cycle,
                // so the strobe is still low for at least STROBE_LO cycles.
                S_LO: begin
                    if (!FETCH_FROM_HI && more_words && cnt_reg == LO_EARLY) begin
                        state_reg <= S_FETCH;
                        wr_ready  <= 1'b1;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == LO_LAST) begin
                        state_reg      <= S_GAP;
                        io_osd         <= 1'b0;
                        cnt_reg        <= '0;
                        abort_seen_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                // Abort beats a simultaneous consume: the offered word is left unread.
                S_FETCH: begin
                    if (abort_any) begin
                        state_reg      <= S_GAP;
                        wr_ready       <= 1'b0;
                        io_osd         <= 1'b0;
                        cnt_reg        <= '0;
                        abort_seen_reg <= 1'b0;
                    end else if (wr_valid) begin
                        state_reg <= S_SETUP;
                        wr_ready  <= 1'b0;
                        io_din    <= wr_data;
                        rem_reg   <= rem_reg - LEN_W'(1);
                    end
                end

                S_SETUP: begin
                    state_reg <= S_HI;
                    io_strobe <= 1'b1;
                    cnt_reg   <= '0;
                end

                S_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= S_IDLE;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    req_ready <= 1'b1;
                    wr_ready  <= 1'b0;
                    busy      <= 1'b0;
                    io_osd    <= 1'b0;
                    io_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule
